// File: rtl/alu_pkg.sv
// Shared opcodes, ALU controls, flag indices and response-slot state for the accumulator
// front-end.
package alu_pkg;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_AND    = 3'b010;
  localparam logic [2:0] OP_OR     = 3'b011;
  localparam logic [2:0] OP_LOAD   = 3'b100;
  localparam logic [2:0] OP_CLRSTK = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam int unsigned FLG_O = 2;
  localparam int unsigned FLG_N = 1;
  localparam int unsigned FLG_Z = 0;

  typedef enum logic {StEmpty, StFull} rsp_state_e;

endpackage

// File: rtl/alu_acc_ctrl_if.sv
// Command/response bundle between an issuer (master) and the accumulator controller (slave).
interface alu_acc_ctrl_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [W-1:0]     cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_acc;
  logic [2:0]       rsp_flags;
  logic             sticky_ovf;
  logic [CNT_W-1:0] op_count;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_acc, rsp_flags, sticky_ovf, op_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_acc, rsp_flags, sticky_ovf, op_count
  );
endinterface

// File: rtl/alu.sv
// Combinational W-bit ALU: add/sub/and/or with signed overflow and true-sign N flag.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   ctrl,
  output logic [W-1:0] y,
  output logic         o,
  output logic         n,
  output logic         z
);

  always_comb begin
    y = '0;
    o = 1'b0;
    unique case (ctrl)
      ALU_ADD: begin
        y = a + b;
        o = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        y = a - b;
        o = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
      end
      ALU_AND: y = a & b;
      default: y = a | b;
    endcase
    // On overflow the wrapped sign is inverted relative to the true result.
    n = y[W-1] ^ o;
    z = (y == '0);
  end

endmodule

// File: rtl/alu_acc_ctrl.sv
// Accumulator front-end: accepts commands, drives the ALU with acc/operand, and holds one
// registered response plus sticky overflow and an operation counter.
module alu_acc_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  alu_acc_ctrl_if.slave bus
);

  rsp_state_e       state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [2:0]       flags_q, flags_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [W-1:0] alu_y;
  logic         alu_o, alu_n, alu_z;
  logic         accept;

  alu #(
    .W(W)
  ) u_alu (
    .a   (acc_q),
    .b   (bus.cmd_data),
    .ctrl(bus.cmd_op[1:0]),
    .y   (alu_y),
    .o   (alu_o),
    .n   (alu_n),
    .z   (alu_z)
  );

  assign bus.cmd_ready  = (state_q == StEmpty) || bus.rsp_ready;
  assign accept         = bus.cmd_valid && bus.cmd_ready;
  assign bus.rsp_valid  = (state_q == StFull);
  assign bus.rsp_acc    = acc_q;
  assign bus.rsp_flags  = flags_q;
  assign bus.sticky_ovf = sticky_q;
  assign bus.op_count   = count_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    flags_d  = flags_q;
    sticky_d = sticky_q;
    count_d  = count_q;

    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (bus.rsp_ready && !accept) state_d = StEmpty;
    endcase

    if (accept) begin
      count_d = count_q + CNT_W'(1);
      case (bus.cmd_op)
        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
          acc_d   = alu_y;
          flags_d = {alu_o, alu_n, alu_z};
          if (alu_o) sticky_d = 1'b1;
        end
        OP_LOAD: begin
          acc_d   = bus.cmd_data;
          flags_d = {1'b0, bus.cmd_data[W-1], bus.cmd_data == '0};
        end
        OP_CLRSTK: begin
          flags_d  = {1'b0, acc_q[W-1], acc_q == '0};
          sticky_d = 1'b0;
        end
        default: flags_d = {1'b0, acc_q[W-1], acc_q == '0};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      acc_q    <= '0;
      flags_q  <= 3'b001;
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Directed bench for alu_acc_ctrl: vector table plus back-pressure, reset and wrap sequences.
module tb_alu_acc_ctrl;
  import alu_pkg::*;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] data;
    logic [15:0] acc;
    logic [2:0]  flags;
    logic        stk;
    logic [7:0]  cnt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[14];

  alu_acc_ctrl_if #(.W(16), .CNT_W(8)) bus ();

  alu_acc_ctrl #(
    .W    (16),
    .CNT_W(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic [15:0] acc, input logic [2:0] flags,
                           input logic stk, input logic [7:0] cnt);
    check({tag, " valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, " acc"}, 32'(bus.rsp_acc), 32'(acc));
    check({tag, " flags"}, 32'(bus.rsp_flags), 32'(flags));
    check({tag, " sticky"}, 32'(bus.sticky_ovf), 32'(stk));
    check({tag, " count"}, 32'(bus.op_count), 32'(cnt));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " acc"}, 32'(bus.rsp_acc), 32'd0);
    check({tag, " flags"}, 32'(bus.rsp_flags), 32'd1);
    check({tag, " valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, " sticky"}, 32'(bus.sticky_ovf), 32'd0);
    check({tag, " count"}, 32'(bus.op_count), 32'd0);
    check({tag, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{OP_LOAD,   16'h7FFF, 16'h7FFF, 3'b000, 1'b0, 8'd1};
    vecs[1]  = '{OP_ADD,    16'h0001, 16'h8000, 3'b100, 1'b1, 8'd2};
    vecs[2]  = '{OP_LOAD,   16'h8000, 16'h8000, 3'b010, 1'b1, 8'd3};
    vecs[3]  = '{OP_SUB,    16'h0001, 16'h7FFF, 3'b110, 1'b1, 8'd4};
    vecs[4]  = '{OP_CLRSTK, 16'h0000, 16'h7FFF, 3'b000, 1'b0, 8'd5};
    vecs[5]  = '{OP_AND,    16'h0F0F, 16'h0F0F, 3'b000, 1'b0, 8'd6};
    vecs[6]  = '{OP_OR,     16'hF000, 16'hFF0F, 3'b010, 1'b0, 8'd7};
    vecs[7]  = '{OP_ADD,    16'h00F1, 16'h0000, 3'b001, 1'b0, 8'd8};
    vecs[8]  = '{OP_SUB,    16'h0001, 16'hFFFF, 3'b010, 1'b0, 8'd9};
    vecs[9]  = '{3'b110,    16'h1234, 16'hFFFF, 3'b010, 1'b0, 8'd10};
    vecs[10] = '{OP_LOAD,   16'h0000, 16'h0000, 3'b001, 1'b0, 8'd11};
    vecs[11] = '{OP_SUB,    16'h8000, 16'h8000, 3'b100, 1'b1, 8'd12};
    vecs[12] = '{3'b111,    16'h0000, 16'h8000, 3'b010, 1'b1, 8'd13};
    vecs[13] = '{OP_CLRSTK, 16'hFFFF, 16'h8000, 3'b010, 1'b0, 8'd14};

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("por");
    rst_n = 1'b1;

    // Streamed table with the consumer always ready: one response per cycle.
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].op, vecs[i].data);
      step();
      check_rsp($sformatf("vec%0d", i), vecs[i].acc, vecs[i].flags, vecs[i].stk, vecs[i].cnt);
    end
    bus.cmd_valid = 1'b0;
    step();
    check("drain valid", 32'(bus.rsp_valid), 32'd0);

    // Overflowing add held unconsumed, then reset mid-cycle drops it.
    bus.rsp_ready = 1'b0;
    issue(OP_ADD, 16'h8000);
    step();
    check_rsp("ovf held", 16'h0000, 3'b111, 1'b1, 8'd15);
    issue(OP_LOAD, 16'h1111);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid rst");
    bus.rsp_ready = 1'b1;
    step();
    check("rst no accept count", 32'(bus.op_count), 32'd0);
    check("rst no accept valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_LOAD, 16'h0ABC);
    step();
    check_rsp("post rst load", 16'h0ABC, 3'b000, 1'b0, 8'd1);

    // Back-pressure: pending LOAD 0x00FF must wait while the response is held.
    bus.cmd_valid = 1'b0;
    step();
    bus.rsp_ready = 1'b0;
    issue(OP_LOAD, 16'h1234);
    step();
    check_rsp("bp first", 16'h1234, 3'b000, 1'b0, 8'd2);
    issue(OP_LOAD, 16'h00FF);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d cmd_ready", i), 32'(bus.cmd_ready), 32'd0);
      step();
      check_rsp($sformatf("bp%0d hold", i), 16'h1234, 3'b000, 1'b0, 8'd2);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp release cmd_ready", 32'(bus.cmd_ready), 32'd1);
    step();
    check_rsp("bp accept", 16'h00FF, 3'b000, 1'b0, 8'd3);
    issue(OP_AND, 16'hFF00);
    step();
    check_rsp("bp stream and", 16'h0000, 3'b001, 1'b0, 8'd4);
    bus.cmd_valid = 1'b0;
    step();
    check("bp drain valid", 32'(bus.rsp_valid), 32'd0);

    // 256 NOPs from reset: counter wraps, acc untouched, O never set.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      issue((i % 2 == 0) ? 3'b110 : 3'b111, 16'h5A5A);
      step();
      check($sformatf("nop%0d flags", i), 32'(bus.rsp_flags), 32'd1);
      if (i == 254) check("nop count 255", 32'(bus.op_count), 32'd255);
    end
    bus.cmd_valid = 1'b0;
    check("nop wrap count", 32'(bus.op_count), 32'd0);
    check("nop acc", 32'(bus.rsp_acc), 32'd0);
    check("nop sticky", 32'(bus.sticky_ovf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
